// File: rtl/fetch_stage_if.sv
// fetch_stage_if: single-outstanding instruction-memory port.
// master = fetch stage (issues requests), slave = instruction memory.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32 instruction-fetch stage. Owns the PC, drives a
// single-outstanding request/response instruction-memory port and fills
// the IF/ID register. Redirects squash in-flight fetches.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect
// targets raise an instruction-address-misaligned marker instead of being
// silently word-aligned).
//
// state | meaning
// IDLE  | reset state, first request issued next cycle
// REQ   | request for fetch_pc presented, waiting for acceptance
// WAIT  | request accepted, waiting for the response
// DROP  | response outstanding for a squashed path, discard it
// HOLD  | response captured in hold buffer while decode is stalled
// FAULT | misaligned redirect reported, no fetching until next redirect
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pc_src,
    input  logic [31:0]   new_pc,
    input  logic          flush,
    input  logic          stall,
    fetch_stage_if.master imem,
    output logic [31:0]   if_id_pc,
    output logic [31:0]   if_id_instruction,
    output logic          if_id_valid,
    output logic          if_id_misaligned
);
    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_HOLD, S_FAULT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_HOLD} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic        req_q, req_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        if_id_mis_q, if_id_mis_d;

    logic        accept;
    logic        stale_out;
    logic        wr_en;
    logic        wr_mis;
    logic [31:0] wr_instr;
    logic [31:0] target_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    // Fault write is deferred one cycle past the redirect so the
    // accompanying flush cannot kill the misaligned marker.
    logic        fault_pend_q, fault_pend_d;
    logic        target_bad;
    assign target_pc  = new_pc;
    assign target_bad = |new_pc[1:0];
`else
    logic [1:0]  unused_new_pc_lsb;
    assign unused_new_pc_lsb = new_pc[1:0];
    assign target_pc = {new_pc[31:2], 2'b00};
`endif

    assign accept = req_q & imem.imem_ready;

    // Next state, fetch PC, hold buffer and IF/ID write request
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        hold_buf_d = hold_buf_q;
        stale_out  = 1'b0;
        wr_en      = 1'b0;
        wr_mis     = 1'b0;
        wr_instr   = NOP;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_pend_d = fault_pend_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                stale_out = accept;
                if (accept) state_d = S_WAIT;
            end
            S_WAIT: begin
                stale_out = !imem.imem_rvalid;
                if (imem.imem_rvalid) begin
                    if (!stall) begin
                        wr_en      = 1'b1;
                        wr_instr   = imem.imem_rdata;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = S_REQ;
                    end else begin
                        hold_buf_d = imem.imem_rdata;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    wr_en      = 1'b1;
                    wr_instr   = hold_buf_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = S_REQ;
                end
            end
            S_DROP: begin
                stale_out = !imem.imem_rvalid;
                if (imem.imem_rvalid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                    state_d = fault_pend_q ? S_FAULT : S_REQ;
`else
                    state_d = S_REQ;
`endif
                end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            S_FAULT: begin
                if (fault_pend_q && !stall) begin
                    wr_en        = 1'b1;
                    wr_mis       = 1'b1;
                    fault_pend_d = 1'b0;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Redirect wins over everything but reset; DROP only if a response is still owed
        if (pc_src) begin
            fetch_pc_d = target_pc;
            wr_en      = 1'b0;
            wr_mis     = 1'b0;
            if (stale_out) begin
                state_d = S_DROP;
            end else begin
                state_d = S_REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
                if (target_bad) state_d = S_FAULT;
`endif
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_pend_d = target_bad;
`endif
        end
    end

    // IF/ID register update: flush beats any write, otherwise hold
    always_comb begin
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if_id_mis_d   = if_id_mis_q;
        if (flush) begin
            if_id_instr_d = NOP;
            if_id_valid_d = 1'b0;
            if_id_mis_d   = 1'b0;
        end else if (wr_en) begin
            if_id_pc_d    = fetch_pc_q;
            if_id_instr_d = wr_instr;
            if_id_valid_d = 1'b1;
            if_id_mis_d   = wr_mis;
        end
    end

    assign req_d = (state_d == S_REQ);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            hold_buf_q    <= 32'h0;
            req_q         <= 1'b0;
            if_id_pc_q    <= 32'h0;
            if_id_instr_q <= NOP;
            if_id_valid_q <= 1'b0;
            if_id_mis_q   <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_pend_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            hold_buf_q    <= hold_buf_d;
            req_q         <= req_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_mis_q   <= if_id_mis_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_pend_q  <= fault_pend_d;
`endif
        end
    end

    assign imem.imem_req     = req_q;
    assign imem.imem_addr    = fetch_pc_q;
    assign if_id_pc          = if_id_pc_q;
    assign if_id_instruction = if_id_instr_q;
    assign if_id_valid       = if_id_valid_q;
    assign if_id_misaligned  = if_id_mis_q;
endmodule
